// File: rtl/frame_deserializer.sv
// frame_deserializer
// Receive-side byte aligner and framer for the 2-bit-per-clock LVDS stream.
// Hunts for SYNC_BYTE at pair granularity, locks byte alignment, checks the
// HEADER (channel 0..2), and emits PAYLOAD_LEN payload bytes tagged with
// sof/eof. Alignment is kept across frames until MISS_LIMIT consecutive sync
// slots are missed.
// Optional feature macro: FRAME_CHECK_EN adds a trailing XOR check byte per
// frame and drives chk_err; without it chk_err is tied to 0.
module frame_deserializer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned MISS_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [1:0] input_data,
  output logic [7:0] output_data,
  output logic       output_valid,
  output logic [1:0] channel,
  output logic       sof,
  output logic       eof,
  output logic       locked,
  output logic       hdr_err,
  output logic       chk_err
);

  typedef enum logic [2:0] {
    ST_HUNT        = 3'd0,
    ST_HEADER      = 3'd1,
    ST_PAYLOAD     = 3'd2,
`ifdef FRAME_CHECK_EN
    ST_CHECK       = 3'd3,
`endif
    ST_EXPECT_SYNC = 3'd4
  } state_t;

  state_t     state_q, state_d;

  // Only the six most recent bits are ever read: the byte being completed on
  // this edge is always next_byte, which includes the incoming pair.
  logic [5:0] sr;
  logic [7:0] next_byte;
  logic [1:0] pair_cnt;
  logic [7:0] byte_cnt;
  logic [3:0] miss_cnt;

  logic byte_done, sync_hit, hdr_ok, last_payload, miss_hit;
  logic lock_set, lock_clr, hdr_good, hdr_bad, emit_byte, miss_inc, miss_clr;

`ifdef FRAME_CHECK_EN
  logic [7:0] chk_acc;
  logic       chk_bad;
`endif

  assign next_byte    = {sr, input_data};
  assign byte_done    = (state_q != ST_HUNT) && (pair_cnt == 2'd3);
  assign sync_hit     = (next_byte == SYNC_BYTE);
  assign hdr_ok       = (next_byte[7:2] == 6'd0) && (next_byte[1:0] != 2'd3);
  assign last_payload = (byte_cnt == 8'(PAYLOAD_LEN - 1));
  assign miss_hit     = ((miss_cnt + 4'd1) == 4'(MISS_LIMIT));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_HUNT;
    else      state_q <= state_d;
  end

  // Next-state decode: HUNT searches every edge, all other states act only
  // when a locked byte completes.
  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HUNT:    if (sync_hit) state_d = ST_HEADER;
      ST_HEADER:  if (byte_done) state_d = hdr_ok ? ST_PAYLOAD : ST_EXPECT_SYNC;
      ST_PAYLOAD: begin
        if (byte_done && last_payload) begin
`ifdef FRAME_CHECK_EN
          state_d = ST_CHECK;
`else
          state_d = ST_EXPECT_SYNC;
`endif
        end
      end
`ifdef FRAME_CHECK_EN
      ST_CHECK:   if (byte_done) state_d = ST_EXPECT_SYNC;
`endif
      ST_EXPECT_SYNC: begin
        if (byte_done) begin
          if (sync_hit)      state_d = ST_HEADER;
          else if (miss_hit) state_d = ST_HUNT;
        end
      end
      default:    state_d = ST_HUNT;
    endcase
  end

  // Output decode: per-edge strobes consumed by the datapath registers.
  always_comb begin
    lock_set  = 1'b0;
    lock_clr  = 1'b0;
    hdr_good  = 1'b0;
    hdr_bad   = 1'b0;
    emit_byte = 1'b0;
    miss_inc  = 1'b0;
    miss_clr  = 1'b0;
`ifdef FRAME_CHECK_EN
    chk_bad   = 1'b0;
`endif
    unique case (state_q)
      ST_HUNT:    lock_set = sync_hit;
      ST_HEADER: begin
        hdr_good = byte_done && hdr_ok;
        hdr_bad  = byte_done && !hdr_ok;
      end
      ST_PAYLOAD: emit_byte = byte_done;
`ifdef FRAME_CHECK_EN
      ST_CHECK:   chk_bad = byte_done && (next_byte != chk_acc);
`endif
      ST_EXPECT_SYNC: begin
        miss_clr = byte_done && sync_hit;
        miss_inc = byte_done && !sync_hit;
        lock_clr = byte_done && !sync_hit && miss_hit;
      end
      default: ;
    endcase
  end

  // Datapath: shift register, counters and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sr           <= '0;
      pair_cnt     <= '0;
      byte_cnt     <= '0;
      miss_cnt     <= '0;
      output_data  <= '0;
      output_valid <= 1'b0;
      channel      <= '0;
      sof          <= 1'b0;
      eof          <= 1'b0;
      locked       <= 1'b0;
      hdr_err      <= 1'b0;
    end else begin
      sr <= next_byte[5:0];

      // Pair counter restarts on the sync edge so the header completes 4 edges later.
      if (lock_set)                pair_cnt <= '0;
      else if (state_q != ST_HUNT) pair_cnt <= pair_cnt + 2'd1;

      if (hdr_good)       byte_cnt <= '0;
      else if (emit_byte) byte_cnt <= byte_cnt + 8'd1;

      if (lock_set || miss_clr) miss_cnt <= '0;
      else if (miss_inc)        miss_cnt <= miss_cnt + 4'd1;

      output_valid <= emit_byte;
      sof          <= emit_byte && (byte_cnt == 8'd0);
      eof          <= emit_byte && last_payload;
      hdr_err      <= hdr_bad;

      if (emit_byte) output_data <= next_byte;
      if (hdr_good)  channel     <= next_byte[1:0];

      if (lock_set)      locked <= 1'b1;
      else if (lock_clr) locked <= 1'b0;
    end
  end

`ifdef FRAME_CHECK_EN
  // Running XOR of the payload and the registered check-mismatch pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      chk_acc <= '0;
      chk_err <= 1'b0;
    end else begin
      if (hdr_good)       chk_acc <= '0;
      else if (emit_byte) chk_acc <= chk_acc ^ next_byte;
      chk_err <= chk_bad;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
